seq_multiplier: RTL and testbench

- Iterative radix-2 shift-add multiplier. Replaces the combinational multiplier beside the ALU in the execute stage.
- Takes the two ALU operands and produces a full 2*WIDTH-bit product over WIDTH cycles, signed or unsigned.
- busy feeds PC logic and regfile write-enable gating as a stall, so the datapath holds while a multiply is in flight.
- done/Zlo feed the ALU/multiplier result mux consumed by data memory address and the busW writeback path.

---
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier.sv | 100 ++++++++++
 tb/tb_seq_multiplier.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the execute stage and the iterative multiplier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             isSigned;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Zlo;
    logic [WIDTH-1:0] Zhi;
    logic             busy;
    logic             done;

    modport master (
        output start, isSigned, X, Y,
        input  Zlo, Zhi, busy, done
    );

    modport slave (
        input  start, isSigned, X, Y,
        output Zlo, Zhi, busy, done
    );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: WIDTH iterations on magnitudes, sign applied to the final product.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    seq_multiplier_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // Upper half accumulates partial sums; lower half starts as the multiplier and shifts out.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   zlo_q, zlo_d;
    logic [WIDTH-1:0]   zhi_q, zhi_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   x_abs;
    logic [WIDTH-1:0]   y_abs;

    always_comb begin
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        step   = {sum, prod_q[WIDTH-1:1]};
        result = (sgn_q && neg_q) ? ('0 - step) : step;
        // The most negative value negates to itself, which is its correct unsigned magnitude.
        x_abs  = (bus.isSigned && bus.X[WIDTH-1]) ? ('0 - bus.X) : bus.X;
        y_abs  = (bus.isSigned && bus.Y[WIDTH-1]) ? ('0 - bus.Y) : bus.Y;
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        zlo_d   = zlo_q;
        zhi_d   = zhi_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    sgn_d   = bus.isSigned;
                    neg_d   = bus.isSigned && (bus.X[WIDTH-1] ^ bus.Y[WIDTH-1]);
                    mcand_d = x_abs;
                    prod_d  = {{WIDTH{1'b0}}, y_abs};
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                prod_d = step;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    zhi_d   = result[2*WIDTH-1:WIDTH];
                    zlo_d   = result[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            zlo_q   <= '0;
            zhi_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
        end
    end

    assign bus.Zlo  = zlo_q;
    assign bus.Zhi  = zhi_q;
    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed table, corner sequences, random vs arithmetic model.
module tb_seq_multiplier;
    localparam int unsigned W = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
        logic [63:0] ax;
        logic [63:0] ay;
        ax = sgn ? {{32{x[31]}}, x} : {32'h0, x};
        ay = sgn ? {{32{y[31]}}, y} : {32'h0, y};
        return ax * ay;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge just after the start edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.X        = x;
        bus.Y        = y;
        bus.isSigned = sgn;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.X        = $urandom;
        bus.Y        = $urandom;
        bus.isSigned = 1'($urandom_range(0, 1));
    endtask

    // Samples each negedge until done; returns at the negedge where done is high.
    task automatic wait_result(output logic [63:0] prod, output int bcnt, output bit seen,
                               output bit held);
        logic [63:0] first;
        first = {bus.Zhi, bus.Zlo};
        prod  = '0;
        bcnt  = 0;
        seen  = 1'b0;
        held  = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.busy) begin
                bcnt++;
                if ({bus.Zhi, bus.Zlo} !== first || bus.done) held = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
                prod = {bus.Zhi, bus.Zlo};
                if (bus.busy) held = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic run_check(input string name, input logic [63:0] exp);
        logic [63:0] prod;
        int          bcnt;
        bit          seen;
        bit          held;
        wait_result(prod, bcnt, seen, held);
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " product"}, prod, exp);
        check({name, " busy cycles"}, 64'(bcnt), 64'd32);
        check({name, " result held while busy"}, 64'(held), 64'd1);
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clk);
        check({name, " done single pulse"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] prod;
        int          bcnt;
        int          dones;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rs;

        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.isSigned = 1'b0;
        bus.X        = '0;
        bus.Y        = '0;

        vecs.push_back('{"u 3*5",        32'h3,        32'h5,        1'b0, 64'h0000_0000_0000_000F});
        vecs.push_back('{"s -3*5",       32'hFFFF_FFFD, 32'h5,       1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
        vecs.push_back('{"u -3*5",       32'hFFFF_FFFD, 32'h5,       1'b0, 64'h0000_0004_FFFF_FFF1});
        vecs.push_back('{"u max*max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{"s min*min",    32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{"s min*1",      32'h8000_0000, 32'h1,       1'b1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{"s 0*-1",       32'h0,        32'hFFFF_FFFF, 1'b1, 64'h0});
        vecs.push_back('{"s -1*-1",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1});

        #12;
        check("reset outputs", {bus.Zhi, bus.Zlo}, 64'h0);
        check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].x, vecs[i].y, vecs[i].sgn);
            run_check(vecs[i].name, vecs[i].exp);
            check_idle_after(vecs[i].name);
        end

        // start held high with changing operands during RUN
        @(negedge clk);
        bus.start    = 1'b1;
        bus.X        = 32'h1234;
        bus.Y        = 32'h10;
        bus.isSigned = 1'b0;
        @(negedge clk);
        bcnt  = 0;
        dones = 0;
        prod  = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dones++;
                prod = {bus.Zhi, bus.Zlo};
            end
            bus.X        = $urandom;
            bus.Y        = $urandom;
            bus.isSigned = 1'($urandom_range(0, 1));
            if (bcnt >= 32 || bus.done) bus.start = 1'b0;
            @(negedge clk);
        end
        check("hold start product", prod, 64'h12340);
        check("hold start done count", 64'(dones), 64'd1);
        check("hold start busy cycles", 64'(bcnt), 64'd32);

        // back-to-back: restart in the done cycle
        issue(32'd3, 32'd5, 1'b0);
        run_check("b2b first", 64'd15);
        bus.start    = 1'b1;
        bus.X        = 32'd7;
        bus.Y        = 32'd6;
        bus.isSigned = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.X     = $urandom;
        bus.Y     = $urandom;
        check("b2b busy rises, done falls", {62'd0, bus.busy, bus.done}, 64'd2);
        run_check("b2b 7*6", 64'h2A);
        check_idle_after("b2b 7*6");

        // asynchronous reset mid-operation
        issue(32'h1234, 32'h5678, 1'b0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset outputs", {bus.Zhi, bus.Zlo}, 64'h0);
        check("async reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("abandoned op silent", 64'(dones), 64'd0);
        issue(32'd2, 32'd2, 1'b0);
        run_check("after reset 2*2", 64'd4);
        check_idle_after("after reset 2*2");

        // random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rx = $urandom;
            ry = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rx = 32'h8000_0000;
                1: ry = 32'h0;
                2: rx = 32'hFFFF_FFFF;
                3: ry = 32'h8000_0000;
                default: ;
            endcase
            issue(rx, ry, rs);
            run_check($sformatf("rand %0d", i), ref_mul(rx, ry, rs));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
